// File: rtl/uart_frame_to_reg_if.sv
// Byte-stream input and decoded-frame output bundle for uart_frame_to_reg.
// The slave modport is the decoder's view; the master modport is the byte source / consumer.
interface uart_frame_to_reg_if #(
    parameter int ERR_CNT_WIDTH = 16
);
    logic [7:0]               rx_data;
    logic                     rx_valid;
    logic                     frame_valid;
    logic [7:0]               address;
    logic [47:0]              regs;
    logic                     in_frame;
    logic                     err_framing;
    logic                     err_timeout;
    logic [ERR_CNT_WIDTH-1:0] err_count;

    modport master (
        output rx_data, rx_valid,
        input  frame_valid, address, regs, in_frame, err_framing, err_timeout, err_count
    );

    modport slave (
        input  rx_data, rx_valid,
        output frame_valid, address, regs, in_frame, err_framing, err_timeout, err_count
    );
endinterface

// File: rtl/uart_frame_to_reg.sv
// Decodes 8-byte register-readback frames (seven LSB=0 data bytes, then a flag byte
// carrying the seven field LSBs) into address/regs, with framing and timeout detection.
module uart_frame_to_reg #(
    parameter int TIMEOUT_CYCLES = 4340,
    parameter int ERR_CNT_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_frame_to_reg_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, HUNT} state_t;

    state_t                   state_q, state_d;
    logic [2:0]               idx_q, idx_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic [6:0]               field_q [7];
    logic [6:0]               store_en;
    logic                     store;
    logic                     frame_valid_q, frame_valid_d;
    logic [7:0]               address_q, address_d;
    logic [47:0]              regs_q, regs_d;
    logic                     err_framing_q, err_framing_d;
    logic                     err_timeout_q, err_timeout_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic [7:0]               dec_address;
    logic [47:0]              dec_regs;

    // Each field's LSB travels in the flag byte, MSB-first in field order.
    assign dec_address = {field_q[0], bus.rx_data[7]};
    for (genvar gi = 0; gi < 6; gi++) begin : g_dec
        assign dec_regs[47-8*gi -: 8] = {field_q[gi+1], bus.rx_data[6-gi]};
    end

    for (genvar gi = 0; gi < 7; gi++) begin : g_field
        assign store_en[gi] = store && (idx_q == 3'(gi));
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                field_q[gi] <= '0;
            end else if (store_en[gi]) begin
                field_q[gi] <= bus.rx_data[7:1];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        store         = 1'b0;
        frame_valid_d = 1'b0;
        address_d     = address_q;
        regs_d        = regs_q;
        err_framing_d = 1'b0;
        err_timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (!bus.rx_data[0]) begin
                        store   = 1'b1;
                        idx_d   = 3'd1;
                        timer_d = '0;
                        state_d = COLLECT;
                    end else begin
                        err_framing_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (bus.rx_valid) begin
                    timer_d = '0;
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
                        if (bus.rx_data[0]) begin
                            frame_valid_d = 1'b1;
                            address_d     = dec_address;
                            regs_d        = dec_regs;
                            state_d       = IDLE;
                        end else begin
                            // Lost the flag: wait for the next LSB=1 byte to realign.
                            err_framing_d = 1'b1;
                            state_d       = HUNT;
                        end
                    end else if (bus.rx_data[0]) begin
                        err_framing_d = 1'b1;
                        idx_d         = 3'd0;
                        state_d       = IDLE;
                    end else begin
                        store = 1'b1;
                        idx_d = idx_q + 3'd1;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    err_timeout_d = 1'b1;
                    idx_d         = 3'd0;
                    timer_d       = '0;
                    state_d       = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HUNT: begin
                if (bus.rx_valid && bus.rx_data[0]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        err_count_d = err_count_q;
        if ((err_framing_d || err_timeout_d) && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            frame_valid_q <= 1'b0;
            address_q     <= '0;
            regs_q        <= '0;
            err_framing_q <= 1'b0;
            err_timeout_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            frame_valid_q <= frame_valid_d;
            address_q     <= address_d;
            regs_q        <= regs_d;
            err_framing_q <= err_framing_d;
            err_timeout_q <= err_timeout_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.frame_valid = frame_valid_q;
    assign bus.address     = address_q;
    assign bus.regs        = regs_q;
    assign bus.in_frame    = (state_q == COLLECT);
    assign bus.err_framing = err_framing_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.err_count   = err_count_q;
endmodule

// File: tb/tb_uart_frame_to_reg.sv
// Directed and randomized byte streams for uart_frame_to_reg, checked against a
// queue-based frame model with a small timeout and counter width.
module tb_uart_frame_to_reg;
    localparam int TO = 40;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    uart_frame_to_reg_if #(.ERR_CNT_WIDTH(CW)) bus ();

    uart_frame_to_reg #(.TIMEOUT_CYCLES(TO), .ERR_CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  partial [$];
    bit          hunting;
    int          gap;
    bit          exp_fv, exp_fe, exp_ft;
    logic [7:0]  exp_addr;
    logic [47:0] exp_regs;
    int          exp_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".frame_valid"}, 64'(bus.frame_valid), 64'(exp_fv));
        chk({tag, ".err_framing"}, 64'(bus.err_framing), 64'(exp_fe));
        chk({tag, ".err_timeout"}, 64'(bus.err_timeout), 64'(exp_ft));
        chk({tag, ".in_frame"},    64'(bus.in_frame),    64'(partial.size() > 0));
        chk({tag, ".err_count"},   64'(bus.err_count),   64'(exp_cnt));
        chk({tag, ".address"},     64'(bus.address),     64'(exp_addr));
        chk({tag, ".regs"},        64'(bus.regs),        64'(exp_regs));
    endtask

    function automatic void count_err();
        if (exp_cnt < CNT_MAX) exp_cnt++;
    endfunction

    function automatic void model_reset();
        partial.delete();
        hunting = 0; gap = 0;
        exp_fv = 0; exp_fe = 0; exp_ft = 0;
        exp_addr = '0; exp_regs = '0; exp_cnt = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] f;
        exp_fv = 0; exp_fe = 0; exp_ft = 0;
        gap = 0;
        if (hunting) begin
            if (b[0]) hunting = 0;
        end else if (partial.size() < 7) begin
            if (b[0]) begin
                exp_fe = 1; count_err(); partial.delete();
            end else begin
                partial.push_back(b);
            end
        end else if (b[0]) begin
            exp_fv = 1;
            exp_regs = '0;
            for (int k = 0; k < 7; k++) begin
                f = (partial[k] & 8'hFE) | 8'((b >> (7 - k)) & 8'd1);
                if (k == 0) exp_addr = f;
                else exp_regs = exp_regs | (48'(f) << (8 * (6 - k)));
            end
            partial.delete();
        end else begin
            exp_fe = 1; count_err(); partial.delete(); hunting = 1;
        end
    endfunction

    function automatic void model_idle();
        exp_fv = 0; exp_fe = 0; exp_ft = 0;
        if (partial.size() > 0) begin
            gap++;
            if (gap == TO) begin
                exp_ft = 1; count_err(); partial.delete(); gap = 0;
            end
        end
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        model_byte(b);
        $display("byte %02h fv=%0d fe=%0d ft=%0d inf=%0d cnt=%0d addr=%02h regs=%012h",
                 b, bus.frame_valid, bus.err_framing, bus.err_timeout, bus.in_frame,
                 bus.err_count, bus.address, bus.regs);
        check_all("byte");
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            model_idle();
            check_all("idle");
        end
    endtask

    // Sends the first nbytes of the encoding of (addr, regs); good_flag=0 clears the flag LSB.
    task automatic send_frame(input logic [7:0] addr, input logic [47:0] regs,
                              input int nbytes, input bit good_flag);
        logic [7:0] f;
        logic [7:0] b7;
        b7 = good_flag ? 8'h01 : 8'h00;
        for (int k = 0; k < 7; k++) begin
            f = (k == 0) ? addr : 8'(regs >> (8 * (6 - k)));
            b7 = b7 | 8'((f & 8'd1) << (7 - k));
            if (k < nbytes) send_byte(f & 8'hFE);
        end
        if (nbytes >= 8) send_byte(b7);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        model_reset();
        $display("reset asserted");
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #10;
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // T1 / T2: good frames, back to back
        send_frame(8'hA5, 48'h123456789ABC, 8, 1);
        chk("t1_addr", 64'(bus.address), 64'h A5);
        chk("t1_regs", 64'(bus.regs), 64'h123456789ABC);
        send_frame(8'hFF, 48'hFFFFFFFFFFFF, 8, 1);
        send_frame(8'hA5, 48'h123456789ABC, 8, 1);

        // T3: early flag
        send_byte(8'hA4); send_byte(8'h12); send_byte(8'h35);
        chk("t3_cnt", 64'(bus.err_count), 64'd1);
        send_frame(8'hA5, 48'h123456789ABC, 8, 1);

        // T4: missing flag, hunt, resync
        send_frame(8'hA5, 48'h123456789ABC, 8, 0);
        send_byte(8'h02);
        send_byte(8'h01);
        send_frame(8'hA5, 48'h123456789ABC, 8, 1);

        // T5: byte on the expiry cycle is accepted, then a real timeout
        send_frame(8'hA5, 48'h123456789ABC, 3, 1);
        idle_cycles(TO - 1);
        send_byte(8'h56);
        idle_cycles(TO + 2);
        chk("t5_inframe", 64'(bus.in_frame), 64'd0);

        // T6: reset mid-frame, then a clean decode
        send_frame(8'h3C, 48'hDEADBEEF0123, 4, 1);
        do_reset();
        send_frame(8'hA5, 48'h123456789ABC, 8, 1);

        // Randomized mix
        for (int it = 0; it < 40; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 5)      send_frame(8'($urandom), {16'($urandom), 32'($urandom)}, 8, 1);
            else if (r == 6) send_byte(8'($urandom));
            else if (r == 7) idle_cycles(int'($urandom_range(0, 2 * TO)));
            else if (r == 8) send_frame(8'($urandom), {16'($urandom), 32'($urandom)},
                                        int'($urandom_range(1, 7)), 1);
            else             send_frame(8'($urandom), {16'($urandom), 32'($urandom)}, 8, 0);
        end
        send_byte(8'h01);

        // Saturation of the error counter
        for (int i = 0; i < CNT_MAX + 5; i++) send_byte(8'h01);
        chk("sat_cnt", 64'(bus.err_count), 64'(CNT_MAX));
        send_frame(8'h5A, 48'hCAFEF00D5555, 8, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
